// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I controller.
// States, opcodes, mux selects and ALU codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_EXECUTEU = 4'd8,
        S_JALRADR  = 4'd9,
        S_ALUWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle: IR fields and flags in,
// datapath strobes and selects out.
interface multicycle_control_unit_if #(
    parameter int ALUCTRL_W = 3
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 zero;
    logic                 lt;
    logic                 mem_ready;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [2:0]           ImmSrc;
    logic                 RegWrite;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 illegal_instr;
    logic [3:0]           state;

    modport master (
        input  opcode, funct3, funct7_5, zero, lt, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl,
        output illegal_instr, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, lt, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl,
        input  illegal_instr, state
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation decoder: ALUOp plus funct fields
// to the 3-bit ALUControl code.
module mc_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    output logic [2:0] alu_ctrl
);

    // op5 separates R-type sub from I-type addi with imm[10] set
    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch..writeback,
// stalls on mem_ready, drives datapath strobes (Moore decode).
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ALUCTRL_W     = 3
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_control_unit_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    logic       ready;
    logic       taken;
    logic       pc_update;
    logic       branch;
    logic       legal_op;
    aluop_t     alu_op;
    logic [2:0] alu_ctrl;

    // Reset gates ready so enables stay low while held in reset
    assign ready = reset & ((MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1);

    // Opcodes the datapath supports
    always_comb begin
        case (bus.opcode)
            OP_LOAD, OP_STORE, OP_R, OP_I,
            OP_LUI, OP_JALR, OP_BRANCH, OP_JAL: legal_op = 1'b1;
            default:                            legal_op = 1'b0;
        endcase
    end

    // Branch condition from funct3; unsigned compares never taken
    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = ~bus.lt;
            default: taken = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:      state_d = S_EXECUTER;
                    OP_I:      state_d = S_EXECUTEI;
                    OP_LUI:    state_d = S_EXECUTEU;
                    OP_JALR:   state_d = S_JALRADR;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR:
                state_d = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_EXECUTEU: state_d = S_ALUWB;
            S_JALRADR:  state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register, asynchronously forced to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Moore output decode per state
    always_comb begin
        pc_update         = 1'b0;
        branch            = 1'b0;
        alu_op            = ALUOP_ADD;
        bus.AdrSrc        = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ResultSrc     = RES_ALUOUT;
        bus.ALUSrcA       = SRCA_PC;
        bus.ALUSrcB       = SRCB_RD2;
        bus.illegal_instr = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                bus.IRWrite   = ready;
                pc_update     = ready;
            end
            S_DECODE: begin
                bus.ALUSrcA       = SRCA_OLDPC;
                bus.ALUSrcB       = SRCB_IMM;
                bus.illegal_instr = ~legal_op;
            end
            S_MEMADR, S_JALRADR, S_EXECUTEI: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                if (state_q == S_EXECUTEI) alu_op = ALUOP_FUNCT;
            end
            S_MEMREAD: bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_FUNCT;
            end
            S_EXECUTEU: begin
                bus.ALUSrcA = SRCA_ZERO;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_ALUWB: bus.RegWrite = 1'b1;
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_update   = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_SUB;
                branch      = 1'b1;
            end
            default: ;
        endcase
    end

    mc_alu_decoder u_alu_dec (
        .alu_op   (alu_op),
        .funct3   (bus.funct3),
        .op5      (bus.opcode[5]),
        .funct7_5 (bus.funct7_5),
        .alu_ctrl (alu_ctrl)
    );

    // Widen the ALU code; upper bits stay zero
    always_comb begin
        bus.ALUControl      = '0;
        bus.ALUControl[2:0] = alu_ctrl;
    end

    assign bus.PCWrite = pc_update | (branch & taken);
    assign bus.ImmSrc  = imm_src(bus.opcode);
    assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit with
// a queue scoreboard checked on the falling edge.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multicycle_control_unit_if #(.ALUCTRL_W(3)) bus();

    multicycle_control_unit #(
        .MEM_HANDSHAKE (1),
        .ALUCTRL_W     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [4:0] en;
        logic [5:0] mux;
        logic [2:0] imm;
        logic [2:0] ac;
        logic       ill;
    } exp_t;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] SD = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] LU = 7'b0110111;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] JR = 7'b1100111;
    localparam logic [6:0] BAD = 7'b1111111;

    exp_t q[$];
    int   idq[$];
    int   n_issued = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t e;
    exp_t a;
    int   id;

    // en = {PCWrite,IRWrite,AdrSrc,MemWrite,RegWrite}
    // mux = {ResultSrc,ALUSrcA,ALUSrcB}
    task automatic vec(
        input logic r, input logic [6:0] op, input logic [2:0] f3,
        input logic f75, input logic z, input logic l, input logic rdy,
        input logic [3:0] st, input logic [4:0] en, input logic [5:0] mux,
        input logic [2:0] imm, input logic [2:0] ac, input logic ill
    );
        @(posedge clk);
        #1;
        reset         = r;
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7_5  = f75;
        bus.zero      = z;
        bus.lt        = l;
        bus.mem_ready = rdy;
        n_issued++;
        q.push_back({st, en, mux, imm, ac, ill});
        idq.push_back(n_issued);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            id = idq.pop_front();
            a = {bus.state, bus.PCWrite, bus.IRWrite, bus.AdrSrc,
                 bus.MemWrite, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.illegal_instr};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d: actual st=%0d en=%b mux=%b imm=%b ac=%b ill=%b, required st=%0d en=%b mux=%b imm=%b ac=%b ill=%b",
                         id, a.st, a.en, a.mux, a.imm, a.ac, a.ill,
                         e.st, e.en, e.mux, e.imm, e.ac, e.ill);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode = R; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0;
        bus.zero = 1'b0; bus.lt = 1'b0; bus.mem_ready = 1'b0;
        #1 reset = 1'b0;
        // held in reset with mem_ready high: enables gated
        vec(0, R, 3'b000, 0, 0, 0, 1, 0, 5'b00000, 6'b100010, 3'b000, 3'b000, 0);
        vec(0, R, 3'b000, 0, 0, 0, 1, 0, 5'b00000, 6'b100010, 3'b000, 3'b000, 0);
        // add
        vec(1, R, 3'b000, 0, 0, 0, 1, 0,  5'b11000, 6'b100010, 3'b000, 3'b000, 0);
        vec(1, R, 3'b000, 0, 0, 0, 1, 1,  5'b00000, 6'b000101, 3'b000, 3'b000, 0);
        vec(1, R, 3'b000, 0, 0, 0, 1, 6,  5'b00000, 6'b001000, 3'b000, 3'b000, 0);
        vec(1, R, 3'b000, 0, 0, 0, 1, 10, 5'b00001, 6'b000000, 3'b000, 3'b000, 0);
        // sub
        vec(1, R, 3'b000, 1, 0, 0, 1, 0,  5'b11000, 6'b100010, 3'b000, 3'b000, 0);
        vec(1, R, 3'b000, 1, 0, 0, 1, 1,  5'b00000, 6'b000101, 3'b000, 3'b000, 0);
        vec(1, R, 3'b000, 1, 0, 0, 1, 6,  5'b00000, 6'b001000, 3'b000, 3'b001, 0);
        vec(1, R, 3'b000, 1, 0, 0, 1, 10, 5'b00001, 6'b000000, 3'b000, 3'b000, 0);
        // addi with bit30 set stays add
        vec(1, I, 3'b000, 1, 0, 0, 1, 0,  5'b11000, 6'b100010, 3'b000, 3'b000, 0);
        vec(1, I, 3'b000, 1, 0, 0, 1, 1,  5'b00000, 6'b000101, 3'b000, 3'b000, 0);
        vec(1, I, 3'b000, 1, 0, 0, 1, 7,  5'b00000, 6'b001001, 3'b000, 3'b000, 0);
        vec(1, I, 3'b000, 1, 0, 0, 1, 10, 5'b00001, 6'b000000, 3'b000, 3'b000, 0);
        // slti, andi
        vec(1, I, 3'b010, 0, 0, 0, 1, 0,  5'b11000, 6'b100010, 3'b000, 3'b000, 0);
        vec(1, I, 3'b010, 0, 0, 0, 1, 1,  5'b00000, 6'b000101, 3'b000, 3'b000, 0);
        vec(1, I, 3'b010, 0, 0, 0, 1, 7,  5'b00000, 6'b001001, 3'b000, 3'b101, 0);
        vec(1, I, 3'b111, 0, 0, 0, 1, 10, 5'b00001, 6'b000000, 3'b000, 3'b000, 0);
        vec(1, I, 3'b111, 0, 0, 0, 1, 0,  5'b11000, 6'b100010, 3'b000, 3'b000, 0);
        vec(1, I, 3'b111, 0, 0, 0, 1, 1,  5'b00000, 6'b000101, 3'b000, 3'b000, 0);
        vec(1, I, 3'b111, 0, 0, 0, 1, 7,  5'b00000, 6'b001001, 3'b000, 3'b010, 0);
        vec(1, I, 3'b111, 0, 0, 0, 1, 10, 5'b00001, 6'b000000, 3'b000, 3'b000, 0);
        // lui
        vec(1, LU, 3'b000, 0, 0, 0, 1, 0,  5'b11000, 6'b100010, 3'b100, 3'b000, 0);
        vec(1, LU, 3'b000, 0, 0, 0, 1, 1,  5'b00000, 6'b000101, 3'b100, 3'b000, 0);
        vec(1, LU, 3'b000, 0, 0, 0, 1, 8,  5'b00000, 6'b001101, 3'b100, 3'b000, 0);
        vec(1, LU, 3'b000, 0, 0, 0, 1, 10, 5'b00001, 6'b000000, 3'b100, 3'b000, 0);
        // lw with two wait states in MEMREAD: 7 cycles
        vec(1, LD, 3'b010, 0, 0, 0, 1, 0, 5'b11000, 6'b100010, 3'b000, 3'b000, 0);
        vec(1, LD, 3'b010, 0, 0, 0, 1, 1, 5'b00000, 6'b000101, 3'b000, 3'b000, 0);
        vec(1, LD, 3'b010, 0, 0, 0, 1, 2, 5'b00000, 6'b001001, 3'b000, 3'b000, 0);
        vec(1, LD, 3'b010, 0, 0, 0, 0, 3, 5'b00100, 6'b000000, 3'b000, 3'b000, 0);
        vec(1, LD, 3'b010, 0, 0, 0, 0, 3, 5'b00100, 6'b000000, 3'b000, 3'b000, 0);
        vec(1, LD, 3'b010, 0, 0, 0, 1, 3, 5'b00100, 6'b000000, 3'b000, 3'b000, 0);
        vec(1, LD, 3'b010, 0, 0, 0, 1, 4, 5'b00001, 6'b010000, 3'b000, 3'b000, 0);
        // sw with one fetch wait state
        vec(1, SD, 3'b010, 0, 0, 0, 0, 0, 5'b00000, 6'b100010, 3'b001, 3'b000, 0);
        vec(1, SD, 3'b010, 0, 0, 0, 1, 0, 5'b11000, 6'b100010, 3'b001, 3'b000, 0);
        vec(1, SD, 3'b010, 0, 0, 0, 1, 1, 5'b00000, 6'b000101, 3'b001, 3'b000, 0);
        vec(1, SD, 3'b010, 0, 0, 0, 1, 2, 5'b00000, 6'b001001, 3'b001, 3'b000, 0);
        vec(1, SD, 3'b010, 0, 0, 0, 1, 5, 5'b00110, 6'b000000, 3'b001, 3'b000, 0);
        // beq zero=1 taken
        vec(1, BR, 3'b000, 0, 1, 0, 1, 0,  5'b11000, 6'b100010, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b000, 0, 1, 0, 1, 1,  5'b00000, 6'b000101, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b000, 0, 1, 0, 1, 11, 5'b10000, 6'b001000, 3'b010, 3'b001, 0);
        // bne zero=1 not taken
        vec(1, BR, 3'b001, 0, 1, 0, 1, 0,  5'b11000, 6'b100010, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b001, 0, 1, 0, 1, 1,  5'b00000, 6'b000101, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b001, 0, 1, 0, 1, 11, 5'b00000, 6'b001000, 3'b010, 3'b001, 0);
        // blt lt=1 taken
        vec(1, BR, 3'b100, 0, 0, 1, 1, 0,  5'b11000, 6'b100010, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b100, 0, 0, 1, 1, 1,  5'b00000, 6'b000101, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b100, 0, 0, 1, 1, 11, 5'b10000, 6'b001000, 3'b010, 3'b001, 0);
        // bge lt=1 not taken
        vec(1, BR, 3'b101, 0, 0, 1, 1, 0,  5'b11000, 6'b100010, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b101, 0, 0, 1, 1, 1,  5'b00000, 6'b000101, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b101, 0, 0, 1, 1, 11, 5'b00000, 6'b001000, 3'b010, 3'b001, 0);
        // funct3=110 never taken even with both flags set
        vec(1, BR, 3'b110, 0, 1, 1, 1, 0,  5'b11000, 6'b100010, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b110, 0, 1, 1, 1, 1,  5'b00000, 6'b000101, 3'b010, 3'b000, 0);
        vec(1, BR, 3'b110, 0, 1, 1, 1, 11, 5'b00000, 6'b001000, 3'b010, 3'b001, 0);
        // illegal opcode
        vec(1, BAD, 3'b000, 0, 0, 0, 1, 0, 5'b11000, 6'b100010, 3'b000, 3'b000, 0);
        vec(1, BAD, 3'b000, 0, 0, 0, 1, 1, 5'b00000, 6'b000101, 3'b000, 3'b000, 1);
        // jal
        vec(1, JL, 3'b000, 0, 0, 0, 1, 0,  5'b11000, 6'b100010, 3'b011, 3'b000, 0);
        vec(1, JL, 3'b000, 0, 0, 0, 1, 1,  5'b00000, 6'b000101, 3'b011, 3'b000, 0);
        vec(1, JL, 3'b000, 0, 0, 0, 1, 12, 5'b10000, 6'b000110, 3'b011, 3'b000, 0);
        vec(1, JL, 3'b000, 0, 0, 0, 1, 10, 5'b00001, 6'b000000, 3'b011, 3'b000, 0);
        // sw interrupted by reset while waiting in MEMWRITE
        vec(1, SD, 3'b010, 0, 0, 0, 1, 0, 5'b11000, 6'b100010, 3'b001, 3'b000, 0);
        vec(1, SD, 3'b010, 0, 0, 0, 1, 1, 5'b00000, 6'b000101, 3'b001, 3'b000, 0);
        vec(1, SD, 3'b010, 0, 0, 0, 1, 2, 5'b00000, 6'b001001, 3'b001, 3'b000, 0);
        vec(1, SD, 3'b010, 0, 0, 0, 0, 5, 5'b00110, 6'b000000, 3'b001, 3'b000, 0);
        vec(1, SD, 3'b010, 0, 0, 0, 0, 5, 5'b00110, 6'b000000, 3'b001, 3'b000, 0);
        vec(0, SD, 3'b010, 0, 0, 0, 1, 0, 5'b00000, 6'b100010, 3'b001, 3'b000, 0);
        // jalr after reset: 5 cycles, PCWrite in JAL
        vec(1, JR, 3'b000, 0, 0, 0, 1, 0,  5'b11000, 6'b100010, 3'b000, 3'b000, 0);
        vec(1, JR, 3'b000, 0, 0, 0, 1, 1,  5'b00000, 6'b000101, 3'b000, 3'b000, 0);
        vec(1, JR, 3'b000, 0, 0, 0, 1, 9,  5'b00000, 6'b001001, 3'b000, 3'b000, 0);
        vec(1, JR, 3'b000, 0, 0, 0, 1, 12, 5'b10000, 6'b000110, 3'b000, 3'b000, 0);
        vec(1, JR, 3'b000, 0, 0, 0, 1, 10, 5'b00001, 6'b000000, 3'b000, 3'b000, 0);
        vec(1, R,  3'b000, 0, 0, 0, 0, 0,  5'b00000, 6'b100010, 3'b000, 3'b000, 0);
        // drain the scoreboard within a bounded number of cycles
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: actual=%0d pending required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
